// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keycode receiver.
//   - kb_state_t  : byte-decode FSM states
//   - PFX_EXT/BRK : set-2 extended and break prefix bytes
//   - HID_*       : HID usage codes produced by the translation table
//   - ps2_to_hid  : set-2 code (+extended flag) -> {hit, hid}
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kb_state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_ESC   = 8'h29;
  localparam logic [7:0] HID_H     = 8'h0B;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_ENTER = 8'h28;
  localparam logic [7:0] HID_UP    = 8'h52;
  localparam logic [7:0] HID_DOWN  = 8'h51;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_RIGHT = 8'h4F;

  typedef struct packed {
    logic       hit;
    logic [7:0] hid;
  } hid_map_t;

  function automatic hid_map_t ps2_to_hid(input logic [7:0] code, input logic ext);
    hid_map_t m;
    m.hit = 1'b1;
    m.hid = HID_NONE;
    if (!ext) begin
      case (code)
        8'h76:   m.hid = HID_ESC;
        8'h33:   m.hid = HID_H;
        8'h1D:   m.hid = HID_W;
        8'h1C:   m.hid = HID_A;
        8'h1B:   m.hid = HID_S;
        8'h23:   m.hid = HID_D;
        8'h29:   m.hid = HID_SPACE;
        8'h5A:   m.hid = HID_ENTER;
        default: m.hit = 1'b0;
      endcase
    end else begin
      case (code)
        8'h75:   m.hid = HID_UP;
        8'h72:   m.hid = HID_DOWN;
        8'h6B:   m.hid = HID_LEFT;
        8'h74:   m.hid = HID_RIGHT;
        default: m.hit = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: bit-level PS/2 frame receiver.
// Ports:
//   MAX10_CLK1_50 in   system clock (rising edge)
//   Reset_h       in   async active-high reset
//   ps2_clk       in   PS/2 clock (async, idle high)
//   ps2_data      in   PS/2 data  (async, idle high)
//   rx_byte       out  last received data byte
//   byte_strobe   out  1-cycle pulse: good frame received
//   frame_err     out  1-cycle pulse: bad frame discarded
// A partial frame idle for TIMEOUT_CYCLES is dropped without error.
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       Reset_h,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    clk_sync;   // [1:0] synchronizer, [2] edge-detect history
  logic [1:0]    data_sync;
  logic [3:0]    bit_cnt;
  logic [10:0]   shreg;
  logic [TW-1:0] tmo_cnt;
  logic          fall;
  logic [10:0]   frame_nxt;
  logic          frame_ok;

  assign fall      = clk_sync[2] & ~clk_sync[1];
  // Bits arrive LSB first; shifting in at the top leaves bit 0 = start.
  assign frame_nxt = {data_sync[1], shreg[10:1]};
  assign frame_ok  = ~frame_nxt[0] & frame_nxt[10] & (^frame_nxt[9:1]);

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      clk_sync    <= 3'b111;
      data_sync   <= 2'b11;
      bit_cnt     <= '0;
      shreg       <= '0;
      tmo_cnt     <= '0;
      rx_byte     <= '0;
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[1:0], ps2_clk};
      data_sync   <= {data_sync[0], ps2_data};
      byte_strobe <= 1'b0;
      frame_err   <= 1'b0;
      // Edge takes priority over a coinciding timeout expiry.
      if (fall) begin
        tmo_cnt <= '0;
        shreg   <= frame_nxt;
        if (bit_cnt == 4'd10) begin
          bit_cnt     <= '0;
          byte_strobe <= frame_ok;
          frame_err   <= ~frame_ok;
          if (frame_ok) rx_byte <= frame_nxt[8:1];
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt <= '0;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 set-2 keyboard to single held-key HID code.
// Ports:
//   MAX10_CLK1_50 in   system clock (rising edge)
//   Reset_h       in   async active-high reset
//   ps2_clk       in   PS/2 clock (async, idle high)
//   ps2_data      in   PS/2 data  (async, idle high)
//   keycode       out  HID code of held key, 8'h00 if none
//   key_valid     out  1-cycle pulse when keycode changes
//   frame_err     out  1-cycle pulse when a frame is discarded
// Last make wins; a break only clears keycode if it matches the held key.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       Reset_h,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       byte_strobe;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .Reset_h       (Reset_h),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .rx_byte       (rx_byte),
    .byte_strobe   (byte_strobe),
    .frame_err     (frame_err)
  );

  kb_state_t  state, next_state;
  logic [7:0] next_key;
  hid_map_t   m_norm, m_ext;

  assign m_norm = ps2_to_hid(rx_byte, 1'b0);
  assign m_ext  = ps2_to_hid(rx_byte, 1'b1);

  always_comb begin
    next_state = state;
    next_key   = keycode;
    if (byte_strobe) begin
      case (state)
        ST_IDLE: begin
          if (rx_byte == PFX_EXT)      next_state = ST_EXT;
          else if (rx_byte == PFX_BRK) next_state = ST_BRK;
          else if (m_norm.hit)         next_key   = m_norm.hid;
        end
        ST_EXT: begin
          if (rx_byte == PFX_BRK) next_state = ST_EXT_BRK;
          else begin
            next_state = ST_IDLE;
            if (m_ext.hit) next_key = m_ext.hid;
          end
        end
        ST_BRK: begin
          next_state = ST_IDLE;
          if (m_norm.hit && keycode == m_norm.hid) next_key = HID_NONE;
        end
        ST_EXT_BRK: begin
          next_state = ST_IDLE;
          if (m_ext.hit && keycode == m_ext.hid) next_key = HID_NONE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      state     <= ST_IDLE;
      keycode   <= HID_NONE;
      key_valid <= 1'b0;
    end else begin
      state     <= next_state;
      keycode   <= next_key;
      key_valid <= (next_key != keycode);
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb_ps2_keycode_rx: directed self-checking bench for ps2_keycode_rx.
module tb_ps2_keycode_rx;

  localparam int HALF = 10;  // PS/2 half bit period, system cycles

  logic       MAX10_CLK1_50 = 1'b0;
  logic       Reset_h = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;

  ps2_keycode_rx #(.TIMEOUT_CYCLES(50000)) dut (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .Reset_h       (Reset_h),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .keycode       (keycode),
    .key_valid     (key_valid),
    .frame_err     (frame_err)
  );

  always #10 MAX10_CLK1_50 = ~MAX10_CLK1_50;

  always @(posedge MAX10_CLK1_50) begin
    if (key_valid) kv_cnt <= kv_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par);
    return {1'b1, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  // Sends nbits of frame f; with lat set, checks key_valid timing around
  // the final falling edge against exp_key.
  task automatic send_bits(input logic [10:0] f, input int nbits,
                           input bit lat, input logic [7:0] exp_key);
    for (int i = 0; i < nbits; i++) begin
      @(negedge MAX10_CLK1_50);
      ps2_data = f[i];
      repeat (HALF) @(negedge MAX10_CLK1_50);
      ps2_clk = 1'b0;
      if (lat && i == nbits - 1) begin
        repeat (3) @(posedge MAX10_CLK1_50);
        #1 chk("kv_early", {31'd0, key_valid}, 32'd0);
        @(posedge MAX10_CLK1_50);
        #1 chk("kv_at_2", {31'd0, key_valid}, 32'd1);
        chk("key_at_2", {24'd0, keycode}, {24'd0, exp_key});
        @(posedge MAX10_CLK1_50);
        #1 chk("kv_1cyc", {31'd0, key_valid}, 32'd0);
        repeat (HALF - 5) @(negedge MAX10_CLK1_50);
      end else begin
        repeat (HALF) @(negedge MAX10_CLK1_50);
      end
      ps2_clk = 1'b1;
    end
    @(negedge MAX10_CLK1_50);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge MAX10_CLK1_50);
  endtask

  task automatic send(input logic [7:0] d);
    send_bits(mk_frame(d, 1'b0), 11, 1'b0, 8'h00);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge MAX10_CLK1_50);
    chk("rst_key", {24'd0, keycode}, 32'h00);
    chk("rst_kv", {31'd0, key_valid}, 32'd0);
    chk("rst_fe", {31'd0, frame_err}, 32'd0);
    Reset_h = 1'b0;
    repeat (5) @(negedge MAX10_CLK1_50);

    // A make with latency check, then break
    send_bits(mk_frame(8'h1C, 1'b0), 11, 1'b1, 8'h04);
    chk("a_make", {24'd0, keycode}, 32'h04);
    chk("a_make_kv", kv_cnt, 1);
    send(8'hF0); send(8'h1C);
    chk("a_brk", {24'd0, keycode}, 32'h00);
    chk("a_brk_kv", kv_cnt, 2);

    // Extended Up, unprefixed 75 ignored, extended break
    send(8'hE0); send(8'h75);
    chk("up_make", {24'd0, keycode}, 32'h52);
    send(8'h75);
    chk("plain75", {24'd0, keycode}, 32'h52);
    chk("plain75_kv", kv_cnt, 3);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_brk", {24'd0, keycode}, 32'h00);
    chk("up_brk_kv", kv_cnt, 4);

    // Typematic Esc
    send(8'h76); send(8'h76); send(8'h76);
    chk("esc_key", {24'd0, keycode}, 32'h29);
    chk("esc_kv", kv_cnt, 5);

    // Bad parity frame
    send_bits(mk_frame(8'h33, 1'b1), 11, 1'b0, 8'h00);
    chk("bad_fe", fe_cnt, 1);
    chk("bad_key", {24'd0, keycode}, 32'h29);

    // Partial frame then timeout, then good H (also proves FSM is IDLE)
    send_bits(mk_frame(8'h33, 1'b0), 5, 1'b0, 8'h00);
    repeat (60000) @(negedge MAX10_CLK1_50);
    send(8'h33);
    chk("tmo_fe", fe_cnt, 1);
    chk("tmo_key", {24'd0, keycode}, 32'h0B);
    chk("tmo_kv", kv_cnt, 6);

    // Last key wins; stale break ignored
    send(8'h1D);
    chk("w_key", {24'd0, keycode}, 32'h1A);
    send(8'h1B);
    chk("s_key", {24'd0, keycode}, 32'h16);
    send(8'hF0); send(8'h1D);
    chk("stale_brk", {24'd0, keycode}, 32'h16);
    chk("stale_kv", kv_cnt, 8);

    // Reset mid-frame, then clean restart
    send_bits(mk_frame(8'h23, 1'b0), 5, 1'b0, 8'h00);
    @(negedge MAX10_CLK1_50);
    Reset_h = 1'b1;
    #1;
    chk("mrst_key", {24'd0, keycode}, 32'h00);
    chk("mrst_kv", {31'd0, key_valid}, 32'd0);
    chk("mrst_fe", {31'd0, frame_err}, 32'd0);
    repeat (3) @(negedge MAX10_CLK1_50);
    Reset_h = 1'b0;
    repeat (5) @(negedge MAX10_CLK1_50);
    send(8'h23);
    chk("d_key", {24'd0, keycode}, 32'h07);
    chk("d_fe", fe_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_keycode_rx.md
PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, is the idle limit in MAX10_CLK1_50 cycles between PS/2 clock falling edges inside a frame (1 ms).
REQ-002 MAX10_CLK1_50  input  1  system clock, 50 MHz; every flop is clocked on its rising edge.
REQ-003 Reset_h  input  1  asynchronous, active-high reset.
REQ-004 ps2_clk  input  1  PS/2 device clock, asynchronous, idle high.
REQ-005 ps2_data  input  1  PS/2 device data, asynchronous, idle high.
REQ-006 keycode  output  8  HID usage code of the held key; 8'h00 when no mapped key is held.
REQ-007 key_valid  output  1  one-cycle pulse whenever keycode changes value.
REQ-008 frame_err  output  1  one-cycle pulse when a received frame is discarded.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer. A third flop on ps2_clk SHALL provide falling-edge detection.
REQ-010 Data SHALL be sampled only in the cycle in which a synchronized ps2_clk falling edge is detected.
REQ-011 Frame format SHALL be: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1 (11 edges total).
REQ-012 On the 11th edge, a frame with start=0, correct odd parity and stop=1 SHALL raise an internal byte strobe for one cycle in the following clock cycle.
REQ-013 Any other frame SHALL be discarded and SHALL pulse frame_err for one cycle in that same following cycle.
REQ-014 A counter SHALL run while a frame is partially received. When it reaches TIMEOUT_CYCLES without a falling edge, the frame SHALL be discarded silently: bit count cleared, no frame_err pulse.
REQ-015 The byte-decode FSM SHALL have four states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: byte E0 -> EXT; byte F0 -> BRK; any other byte -> make(normal), stay IDLE.
  - EXT: byte F0 -> EXT_BRK; any other byte -> make(extended), then IDLE.
  - BRK: any byte -> break(normal), then IDLE.
  - EXT_BRK: any byte -> break(extended), then IDLE.
REQ-016 Translation table, from PS/2 set-2 code to HID code:
  - Normal keys: 76->29 (Esc), 33->0B (H), 1D->1A (W), 1C->04 (A), 1B->16 (S), 23->07 (D), 29->2C (Space), 5A->28 (Enter).
  - Extended keys: 75->52 (Up), 72->51 (Down), 6B->50 (Left), 74->4F (Right).
  - All other codes are unmapped.
REQ-017 make on a mapped key SHALL load keycode with its HID code.
REQ-018 break on a mapped key SHALL set keycode to 8'h00 only if keycode currently equals that key's HID code; otherwise keycode is unchanged.
REQ-019 Unmapped makes and breaks SHALL leave keycode unchanged. The FSM SHALL still advance per REQ-015.
REQ-020 keycode and key_valid SHALL update in the cycle after the byte strobe, i.e. 2 cycles after the stop-bit edge is detected.
REQ-021 key_valid SHALL pulse only if the new keycode differs from the old one. A typematic repeat of the held key SHALL produce no pulse.
REQ-022 A second mapped make while a key is held SHALL replace keycode (last key wins). The later break of the first key SHALL then have no effect.
REQ-023 If a falling edge coincides with a timeout expiry, the edge SHALL win: its bit is sampled and the counter is cleared.

Reset
REQ-024 Reset_h SHALL asynchronously clear the following:
  - keycode=8'h00, key_valid=0, frame_err=0;
  - FSM=IDLE;
  - bit counter, shift register and timeout counter;
  - synchronizer flops, set to 1 (idle).
REQ-025 A reset asserted mid-frame SHALL discard the partial frame. Reception SHALL restart cleanly at the next start bit after release.

Structure
REQ-026 Package ps2_pkg SHALL hold the FSM state enum, the E0/F0 prefix constants, and the HID code constants (including 8'h29 Esc and 8'h0B H, which the game top decodes).
REQ-027 Bit-level reception (REQ-009 to REQ-014, REQ-023) SHALL be a sub-module ps2_frame_rx with outputs byte[7:0], byte_strobe and frame_err. ps2_keycode_rx SHALL contain the FSM and the translation table.

Verification
REQ-028 Frame 1C (A) -> keycode=04 and a single key_valid pulse 2 cycles after the stop edge. Then F0 1C -> keycode=00 and one key_valid pulse.
REQ-029 E0 75 -> keycode=52. Then E0 F0 75 -> keycode=00. Also: a normal 75 with no E0 prefix -> keycode unchanged.
REQ-030 76 sent three times (typematic repeat) -> keycode=29 with exactly one key_valid pulse.
REQ-031 Error and timeout frames:
  - Frame 33 with bad parity -> frame_err pulse, keycode unchanged, FSM stays IDLE.
  - 5 bits, then 60000 idle cycles, then a valid 33 -> no frame_err, keycode=0B.
REQ-032 1D (W) then 1B (S), then F0 1D -> keycode=16 throughout the break.
REQ-033 Reset_h asserted after bit 4 of frame 23 -> all outputs 0 immediately. The next full 23 frame -> keycode=07.
